sobel_stream: RTL and testbench
===============================

Name: sobel_stream

Overview:
Parametrised streaming 3x3 Sobel edge engine for the camera -> grayscale -> frame-memory pipeline. It replaces the fixed-size, fixed-mode Sobel stage. Image width, height and pixel width are parameters, and the output mode is selectable: magnitude, binary threshold, |Gx| only or |Gy| only. It consumes a raster-order pixel stream with arbitrary valid gaps, emits one result per interior pixel, and pulses at end of frame.

Parameters:
IMG_W, 160, pixels per line (>=3)
IMG_H, 120, lines per frame (>=3)
DW, 8, pixel width in bits; MAXV = 2^DW-1

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous frame abort; counters and pipeline valids cleared
in_valid  input  1  in_data is a pixel this cycle
in_data  input  DW  grayscale pixel, raster order, row 0 col 0 first
mode  input  2  0=|Gx|+|Gy|, 1=binary threshold, 2=|Gx|, 3=|Gy|
threshold  input  DW  compare level for mode 1
out_valid  output  1  out_data valid this cycle
out_data  output  DW  filtered interior pixel
frame_done  output  1  one-cycle pulse with the last output of a frame
busy  output  1  frame in progress

Behaviour:
- Reset (rst_n=0, async): out_valid=0, out_data=0, frame_done=0, busy=0, col=0, row=0, pipeline valids=0. Line buffers are not reset.
- clear=1 has the same effect synchronously. It has priority over in_valid the same cycle, and no frame_done is produced for the aborted frame.
- Storage: two line buffers of IMG_W x DW (rows r-1, r-2) and a 3x3 window register p[i][j]. i=0 is the oldest row, j=0 is the leftmost column. The window, line buffers and col/row advance only on in_valid.
- col counts 0..IMG_W-1 and wraps, incrementing row. row counts 0..IMG_H-1 and wraps to 0, which starts the next frame with no idle cycle required.
- mode/threshold are latched on the beat with row=0,col=0 and held for the whole frame. Changes mid-frame have no effect.
- busy goes 1 on the row0/col0 beat and returns to 0 on the cycle after frame_done.
- Qualifying beat: an in_valid beat with row>=2 and col>=2. Its window is centred at (row-1, col-1). Exactly (IMG_W-2)*(IMG_H-2) outputs are produced per frame; border pixels produce nothing.
- Arithmetic:
  - Gx = (p02+2p12+p22)-(p00+2p10+p20)
  - Gy = (p20+2p21+p22)-(p00+2p01+p02)
  - Gx and Gy are signed, DW+3 bits.
  - |Gx|, |Gy| are <= 4*MAXV. Their sum is DW+3 bits unsigned and must not overflow.
  - Modes 0/2/3: result saturates to MAXV.
  - Mode 1: out = MAXV if (|Gx|+|Gy|) >= threshold (unsaturated compare), else 0.
- Pipeline:
  - Stage 1 registers Gx/Gy; stage 2 registers the mode result.
  - out_valid is high exactly in the cycle following the second rising edge after the qualifying beat's sampling edge (latency 2, independent of in_valid gaps). Stages advance every clock, not only on in_valid.
  - out_valid=1 for one cycle per qualifying beat. Back-to-back beats give back-to-back outputs. out_data holds its last value when out_valid=0.
- frame_done is asserted coincident with out_valid for the qualifying beat at row=IMG_H-1, col=IMG_W-1.
- If the next frame's first beat arrives while the previous frame's last output is still in the pipeline, both complete correctly. Latched mode travels with the pipeline data.
- No backpressure: the downstream must accept every out_valid beat.

Test Plan:
1. IMG_W=8, IMG_H=6, DW=8, mode 0, constant 100 frame, contiguous in_valid -> 24 outputs, all 0; single frame_done on the 24th; busy low afterwards.
2. Same size, step image (cols 0-3 = 0, cols 4-7 = 255), mode 0 -> each of 4 output rows reads 0,0,255,255,0,0 (Gx=1020 saturated). Repeat in mode 3 -> all 0. Repeat in mode 2 -> identical to mode 0.
3. Ramp image pixel=col*10, mode 0 -> every output 80 (Gx=80, Gy=0). Mode 1 with threshold=80 -> all 255. Mode 1 with threshold=81 -> all 0.
4. Test 3 input with random 0-3 cycle in_valid gaps -> identical output sequence; each out_valid exactly 2 cycles after its qualifying beat.
5. Mid-frame events:
   - Assert rst_n=0 at row 3 -> all outputs drop immediately; a following full frame gives the correct 24 results.
   - Repeat with clear instead -> same behaviour, and no frame_done for the aborted frame.
6. Two back-to-back frames with no gap, frame A mode 0 step, frame B mode 1 threshold=200 step, mode changed mid-frame A to 3 -> A is unaffected; 48 outputs total; exactly two frame_done pulses.

Source files
------------

// File: rtl/sobel_stream_if.sv
// Valid/data pixel stream carrying one DW-bit sample per asserted valid.
`timescale 1ns/1ps
interface sobel_stream_if #(
   parameter int unsigned DW = 8
);
   logic          valid;
   logic [DW-1:0] data;

   modport master (output valid, output data);
   modport slave  (input  valid, input  data);
endinterface

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel engine: raster pixels in, one result per interior pixel out.
// Window/line buffers advance on input beats; the two result stages advance every clock.
`timescale 1ns/1ps
module sobel_stream #(
   parameter int unsigned IMG_W = 160,
   parameter int unsigned IMG_H = 120,
   parameter int unsigned DW    = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clear,
   sobel_stream_if.slave   in_if,
   input  logic [1:0]      mode,
   input  logic [DW-1:0]   threshold,
   sobel_stream_if.master  out_if,
   output logic            frame_done,
   output logic            busy
);

   localparam int unsigned CW = $clog2(IMG_W);
   localparam int unsigned RW = $clog2(IMG_H);
   localparam int unsigned AW = DW + 2;
   localparam int unsigned SW = DW + 3;
   localparam logic [SW-1:0] MaxExt = SW'({DW{1'b1}});

   typedef enum logic [1:0] {ModeMag, ModeThr, ModeGx, ModeGy} mode_e;

   logic [CW-1:0]        col_q;
   logic [RW-1:0]        row_q;
   logic [DW-1:0]        lb1_q [IMG_W];
   logic [DW-1:0]        lb2_q [IMG_W];
   logic [DW-1:0]        win_q [3][3];
   mode_e                frame_mode_q, s1_mode_q;
   logic [DW-1:0]        frame_thr_q, s1_thr_q;
   logic                 v0_q, v0_last_q, s1_valid_q, s1_last_q;
   logic signed [SW-1:0] gx_q, gy_q, gx_d, gy_d;
   logic                 out_valid_q, frame_done_q, busy_q, busy_d;
   logic [DW-1:0]        out_data_q, result_d;
   logic [AW-1:0]        gx_pos, gx_neg, gy_pos, gy_neg;
   logic [SW-1:0]        ax, ay, sum;
   logic                 beat, col_last, row_last, frame_start, qual;

   function automatic logic [DW-1:0] sat(input logic [SW-1:0] v);
      return (v > MaxExt) ? {DW{1'b1}} : v[DW-1:0];
   endfunction

   always_comb begin
      beat        = in_if.valid;
      col_last    = (col_q == CW'(IMG_W - 1));
      row_last    = (row_q == RW'(IMG_H - 1));
      frame_start = beat && (row_q == '0) && (col_q == '0);
      qual        = beat && (row_q >= RW'(2)) && (col_q >= CW'(2));
   end

   // Row 0 of the window is the oldest line, column 2 the newest pixel.
   always_comb begin
      gx_pos = AW'(win_q[0][2]) + AW'({win_q[1][2], 1'b0}) + AW'(win_q[2][2]);
      gx_neg = AW'(win_q[0][0]) + AW'({win_q[1][0], 1'b0}) + AW'(win_q[2][0]);
      gy_pos = AW'(win_q[2][0]) + AW'({win_q[2][1], 1'b0}) + AW'(win_q[2][2]);
      gy_neg = AW'(win_q[0][0]) + AW'({win_q[0][1], 1'b0}) + AW'(win_q[0][2]);
      gx_d   = $signed(SW'(gx_pos)) - $signed(SW'(gx_neg));
      gy_d   = $signed(SW'(gy_pos)) - $signed(SW'(gy_neg));
   end

   always_comb begin
      ax       = gx_q[SW-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
      ay       = gy_q[SW-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
      sum      = ax + ay;
      result_d = '0;
      unique case (s1_mode_q)
         ModeMag: result_d = sat(sum);
         ModeThr: result_d = (sum >= SW'(s1_thr_q)) ? {DW{1'b1}} : '0;
         ModeGx:  result_d = sat(ax);
         ModeGy:  result_d = sat(ay);
      endcase
   end

   // A new frame may start while the previous one's last output is still in flight.
   always_comb begin
      busy_d = busy_q;
      if (frame_done_q && (row_q == '0) && (col_q == '0)) busy_d = 1'b0;
      if (frame_start) busy_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (beat) begin
         lb2_q[col_q] <= lb1_q[col_q];
         lb1_q[col_q] <= in_if.data;
         for (int i = 0; i < 3; i++) begin
            win_q[i][0] <= win_q[i][1];
            win_q[i][1] <= win_q[i][2];
         end
         win_q[0][2] <= lb2_q[col_q];
         win_q[1][2] <= lb1_q[col_q];
         win_q[2][2] <= in_if.data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q        <= '0;
         row_q        <= '0;
         frame_mode_q <= ModeMag;
         frame_thr_q  <= '0;
         v0_q         <= 1'b0;
         v0_last_q    <= 1'b0;
         s1_valid_q   <= 1'b0;
         s1_last_q    <= 1'b0;
         s1_mode_q    <= ModeMag;
         s1_thr_q     <= '0;
         gx_q         <= '0;
         gy_q         <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
      end else if (clear) begin
         col_q        <= '0;
         row_q        <= '0;
         v0_q         <= 1'b0;
         v0_last_q    <= 1'b0;
         s1_valid_q   <= 1'b0;
         s1_last_q    <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         if (beat) begin
            col_q <= col_last ? '0 : col_q + 1'b1;
            if (col_last) row_q <= row_last ? '0 : row_q + 1'b1;
         end
         if (frame_start) begin
            frame_mode_q <= mode_e'(mode);
            frame_thr_q  <= threshold;
         end
         v0_q       <= qual;
         v0_last_q  <= qual && row_last && col_last;
         s1_valid_q <= v0_q;
         s1_last_q  <= v0_last_q;
         if (v0_q) begin
            gx_q      <= gx_d;
            gy_q      <= gy_d;
            s1_mode_q <= frame_mode_q;
            s1_thr_q  <= frame_thr_q;
         end
         out_valid_q  <= s1_valid_q;
         frame_done_q <= s1_valid_q && s1_last_q;
         if (s1_valid_q) out_data_q <= result_d;
         busy_q <= busy_d;
      end
   end

   assign out_if.valid = out_valid_q;
   assign out_if.data  = out_data_q;
   assign frame_done   = frame_done_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_sobel_stream.sv
// Directed bench for sobel_stream on an 8x6 image with a queue-based Sobel reference model.
`timescale 1ns/1ps
module tb_sobel_stream;
   localparam int W  = 8;
   localparam int H  = 6;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clear = 1'b0;
   logic [1:0]    mode = 2'd0;
   logic [DW-1:0] threshold = '0;
   logic          frame_done, busy;

   sobel_stream_if #(.DW(DW)) in_if ();
   sobel_stream_if #(.DW(DW)) out_if ();

   sobel_stream #(.IMG_W(W), .IMG_H(H), .DW(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_if     (in_if),
      .mode      (mode),
      .threshold (threshold),
      .out_if    (out_if),
      .frame_done(frame_done),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int     data;
      bit     last;
      longint cyc;
   } exp_t;

   exp_t   exp_q[$];
   int     cap[$];
   int     img[H][W];
   int     errors = 0;
   int     checks = 0;
   int     fd_cnt = 0;
   int     out_cnt = 0;
   longint cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Reference Sobel on the stored image, centred at (r, c).
   function automatic int exp_pix(input int r, input int c, input int md, input int thr);
      int gx, gy, ax, ay, s;
      gx = (img[r-1][c+1] + 2 * img[r][c+1] + img[r+1][c+1])
         - (img[r-1][c-1] + 2 * img[r][c-1] + img[r+1][c-1]);
      gy = (img[r+1][c-1] + 2 * img[r+1][c] + img[r+1][c+1])
         - (img[r-1][c-1] + 2 * img[r-1][c] + img[r-1][c+1]);
      ax = (gx < 0) ? -gx : gx;
      ay = (gy < 0) ? -gy : gy;
      s  = ax + ay;
      case (md)
         0: return (s > 255) ? 255 : s;
         1: return (s >= thr) ? 255 : 0;
         2: return (ax > 255) ? 255 : ax;
         default: return (ay > 255) ? 255 : ay;
      endcase
   endfunction

   function automatic void fill(input int pat);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            case (pat)
               0: img[r][c] = 100;
               1: img[r][c] = (c >= 4) ? 255 : 0;
               2: img[r][c] = c * 10;
               default: img[r][c] = int'($urandom_range(255, 0));
            endcase
   endfunction

   always @(negedge clk) begin
      if (out_if.valid) begin
         out_cnt++;
         cap.push_back(int'(out_if.data));
         if (frame_done) fd_cnt++;
         chk("exp_avail", int'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("out_data", int'(out_if.data), e.data);
            chk("frame_done", int'(frame_done), int'(e.last));
            chk("latency_cyc", int'(cyc), int'(e.cyc));
         end
      end else begin
         chk("frame_done_idle", int'(frame_done), 0);
      end
   end

   // Drives one frame; stop_row>=0 aborts before beat (stop_row, 4).
   task automatic send_frame(input int md, input int thr, input int gapmax,
                             input int stop_row, input bit chg_mid);
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            if (r == stop_row && c == 4) begin
               in_if.valid = 1'b0;
               return;
            end
            repeat (int'($urandom_range(gapmax, 0))) begin
               in_if.valid = 1'b0;
               @(posedge clk); #1;
            end
            if (r == 0 && c == 0) begin
               mode      = 2'(md);
               threshold = 8'(thr);
            end
            if (chg_mid && r == 2 && c == 0) begin
               mode      = 2'd3;
               threshold = 8'd0;
            end
            in_if.valid = 1'b1;
            in_if.data  = 8'(img[r][c]);
            if (r >= 2 && c >= 2) begin
               exp_t e;
               e.data = exp_pix(r - 1, c - 1, md, thr);
               e.last = (r == H - 1) && (c == W - 1);
               e.cyc  = cyc + 3;
               exp_q.push_back(e);
            end
            @(posedge clk); #1;
         end
      end
      in_if.valid = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 40; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk); #2;
      end
      chk(name, exp_q.size(), 0);
      @(posedge clk); #1;
      chk("busy_after_frame", int'(busy), 0);
   endtask

   initial begin
      int fd0, oc0;
      int lit[6];
      lit = '{0, 0, 255, 255, 0, 0};
      in_if.valid = 1'b0;
      in_if.data  = '0;
      #1;
      chk("rst_out_valid", int'(out_if.valid), 0);
      chk("rst_out_data", int'(out_if.data), 0);
      chk("rst_frame_done", int'(frame_done), 0);
      chk("rst_busy", int'(busy), 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Constant frame: 24 zero outputs, one frame_done.
      fill(0);
      fd0 = fd_cnt; oc0 = out_cnt;
      send_frame(0, 0, 0, -1, 1'b0);
      drain("t1_drain");
      chk("t1_outputs", out_cnt - oc0, 24);
      chk("t1_frame_done", fd_cnt - fd0, 1);

      // Step edge, modes 0, 3, 2.
      fill(1);
      chk("model_step_c3", exp_pix(1, 3, 0, 0), 255);
      chk("model_step_c4", exp_pix(1, 4, 2, 0), 255);
      chk("model_step_gy", exp_pix(1, 4, 3, 0), 0);
      cap.delete();
      send_frame(0, 0, 0, -1, 1'b0);
      drain("t2_drain_m0");
      chk("t2_cap_size", int'(cap.size() >= 6), 1);
      if (cap.size() >= 6)
         for (int i = 0; i < 6; i++) chk("t2_step_row", cap[i], lit[i]);
      send_frame(3, 0, 0, -1, 1'b0);
      drain("t2_drain_m3");
      send_frame(2, 0, 0, -1, 1'b0);
      drain("t2_drain_m2");

      // Ramp: magnitude and threshold boundary.
      fill(2);
      chk("model_ramp", exp_pix(2, 2, 0, 0), 80);
      chk("model_thr80", exp_pix(2, 2, 1, 80), 255);
      chk("model_thr81", exp_pix(2, 2, 1, 81), 0);
      send_frame(0, 0, 0, -1, 1'b0);
      drain("t3_drain_m0");
      send_frame(1, 80, 0, -1, 1'b0);
      drain("t3_drain_t80");
      send_frame(1, 81, 0, -1, 1'b0);
      drain("t3_drain_t81");

      // Same ramp with random input gaps.
      send_frame(0, 0, 3, -1, 1'b0);
      drain("t4_drain_gaps");

      // Mid-frame asynchronous reset, then a clean frame.
      send_frame(0, 0, 0, 3, 1'b0);
      chk("t5_busy_mid", int'(busy), 1);
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("t5_rst_valid", int'(out_if.valid), 0);
      chk("t5_rst_data", int'(out_if.data), 0);
      chk("t5_rst_busy", int'(busy), 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      oc0 = out_cnt;
      send_frame(0, 0, 0, -1, 1'b0);
      drain("t5_rst_drain");
      chk("t5_rst_outputs", out_cnt - oc0, 24);

      // Mid-frame clear, with a competing input beat in the same cycle.
      fd0 = fd_cnt;
      send_frame(0, 0, 0, 3, 1'b0);
      clear       = 1'b1;
      in_if.valid = 1'b1;
      in_if.data  = 8'd77;
      exp_q.delete();
      @(posedge clk); #1;
      clear       = 1'b0;
      in_if.valid = 1'b0;
      chk("t5_clr_valid", int'(out_if.valid), 0);
      chk("t5_clr_busy", int'(busy), 0);
      oc0 = out_cnt;
      send_frame(0, 0, 0, -1, 1'b0);
      drain("t5_clr_drain");
      chk("t5_clr_outputs", out_cnt - oc0, 24);
      chk("t5_clr_frame_done", fd_cnt - fd0, 1);

      // Back-to-back frames with a mid-frame mode change on frame A.
      fill(1);
      fd0 = fd_cnt; oc0 = out_cnt;
      send_frame(0, 0, 0, -1, 1'b1);
      send_frame(1, 200, 0, -1, 1'b0);
      drain("t6_drain");
      chk("t6_outputs", out_cnt - oc0, 48);
      chk("t6_frame_done", fd_cnt - fd0, 2);

      // Random image, gaps, magnitude then threshold.
      fill(3);
      send_frame(0, 0, 2, -1, 1'b0);
      send_frame(1, 128, 2, -1, 1'b0);
      drain("t7_drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: got t=%0t required completion", $time);
      $fatal(1);
   end
endmodule
